// File: rtl/test_monitor.sv
// test_monitor: shadows per-hart done/result/testnum writebacks and
// reports a registered pass/fail/timeout verdict plus a cycle counter.
module test_monitor #(
    parameter int NUM_HARTS      = 1,
    parameter int XLEN           = 32,
    parameter int DONE_REG       = 26,
    parameter int RESULT_REG     = 27,
    parameter int TESTNUM_REG    = 3,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int CNT_W          = 32,
    localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_HARTS-1:0]      wb_en,
    input  logic [5*NUM_HARTS-1:0]    wb_addr,
    input  logic [XLEN*NUM_HARTS-1:0] wb_data,
    output logic                      sim_done,
    output logic                      test_pass,
    output logic                      test_fail,
    output logic                      test_timeout,
    output logic [HART_W-1:0]         fail_hart,
    output logic [XLEN-1:0]           fail_testnum,
    output logic [CNT_W-1:0]          cycle_cnt
);

    typedef enum logic [1:0] {
        RUN,
        SETTLE,
        DONE,
        TIMEOUT
    } state_t;

    localparam logic [4:0] DONE_IDX = 5'(DONE_REG);
    localparam logic [4:0] RES_IDX  = 5'(RESULT_REG);
    localparam logic [4:0] TN_IDX   = 5'(TESTNUM_REG);

    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    localparam logic [7:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t state;
    state_t state_d;

    logic [4:0]      lane_addr [NUM_HARTS];
    logic [XLEN-1:0] lane_data [NUM_HARTS];

    logic [NUM_HARTS-1:0] done_q;
    logic [NUM_HARTS-1:0] done_d;
    logic [XLEN-1:0]      res_q [NUM_HARTS];
    logic [XLEN-1:0]      res_d [NUM_HARTS];
    logic [XLEN-1:0]      tn_q  [NUM_HARTS];
    logic [XLEN-1:0]      tn_d  [NUM_HARTS];

    logic       live;
    logic       all_done;
    logic [7:0] settle_cnt;

    logic              enter_done;
    logic              enter_tmo;
    logic              all_pass;
    logic [HART_W-1:0] bad_idx;
    logic [XLEN-1:0]   bad_tn;
    logic [HART_W-1:0] idle_idx;
    logic [XLEN-1:0]   idle_tn;

    // Shadows and the counter only move while the test is still running.
    assign live = (state == RUN) || (state == SETTLE);

    // Split the packed writeback buses into per-hart lanes.
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            lane_addr[h] = wb_addr[5*h +: 5];
            lane_data[h] = wb_data[XLEN*h +: XLEN];
        end
    end

    // Next-state shadows: this cycle's writes folded into the stored copies.
    always_comb begin
        done_d = done_q;
        res_d  = res_q;
        tn_d   = tn_q;
        if (live) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wb_en[h] && (lane_addr[h] != 5'd0)) begin
                    if ((lane_addr[h] == DONE_IDX) &&
                        (lane_data[h] == ONE)) begin
                        done_d[h] = 1'b1;
                    end
                    if (lane_addr[h] == RES_IDX) begin
                        res_d[h] = lane_data[h];
                    end
                    if (lane_addr[h] == TN_IDX) begin
                        tn_d[h] = lane_data[h];
                    end
                end
            end
        end
    end

    assign all_done = &done_d;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state; all-done beats the timeout on a same-cycle tie.
    always_comb begin
        state_d = state;
        unique case (state)
            RUN: begin
                if (all_done) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                    end
                end else if (cycle_cnt == TMO_LAST) begin
                    state_d = TIMEOUT;
                end
            end
            SETTLE: begin
                if (settle_cnt == 8'd0) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = DONE;
            TIMEOUT: state_d = TIMEOUT;
        endcase
    end

    // FSM outputs: transition strobes and verdict from next-state shadows.
    always_comb begin
        enter_done = (state != DONE) && (state_d == DONE);
        enter_tmo  = (state != TIMEOUT) && (state_d == TIMEOUT);
        all_pass   = 1'b1;
        bad_idx    = '0;
        bad_tn     = '0;
        idle_idx   = '0;
        idle_tn    = '0;
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (res_d[h] != ONE) begin
                all_pass = 1'b0;
                bad_idx  = HART_W'(h);
                bad_tn   = tn_d[h];
            end
            if (!done_d[h]) begin
                idle_idx = HART_W'(h);
                idle_tn  = tn_d[h];
            end
        end
    end

    // Shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                res_q[h] <= '0;
                tn_q[h]  <= '0;
            end
        end else begin
            done_q <= done_d;
            for (int h = 0; h < NUM_HARTS; h++) begin
                res_q[h] <= res_d[h];
                tn_q[h]  <= tn_d[h];
            end
        end
    end

    // Settle window countdown, loaded on entry to SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 8'd0;
        end else if ((state == RUN) && (state_d == SETTLE)) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == SETTLE) && (settle_cnt != 8'd0)) begin
            settle_cnt <= settle_cnt - 8'd1;
        end
    end

    // Saturating cycle counter, frozen once the test has ended.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (live && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // Sticky verdict registers, loaded on entry to DONE or TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            sim_done     <= 1'b0;
            test_pass    <= 1'b0;
            test_fail    <= 1'b0;
            test_timeout <= 1'b0;
            fail_hart    <= '0;
            fail_testnum <= '0;
        end else if (enter_done) begin
            sim_done     <= 1'b1;
            test_pass    <= all_pass;
            test_fail    <= !all_pass;
            fail_hart    <= bad_idx;
            fail_testnum <= bad_tn;
        end else if (enter_tmo) begin
            test_timeout <= 1'b1;
            fail_hart    <= idle_idx;
            fail_testnum <= idle_tn;
        end
    end

endmodule
